// File: rtl/ai_paddle_top.sv
// Computer-controlled top paddle: on each frame tick it erases itself, steps one pixel toward the ball
// (or toward centre), then redraws. Optional build macro AI_JITTER_EN adds LFSR aim jitter.
module ai_paddle_top #(
    parameter int          PADDLE_W     = 16,
    parameter int          PADDLE_Y     = 10,
    parameter int          XMIN         = 51,
    parameter int          XMAX         = 108,
    parameter logic [2:0]  PADDLE_COLOR = 3'b110
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       difficulty,
    input  logic [7:0] ball_x,
    input  logic [6:0] ball_y,
    input  logic       ball_y_dir,
    output logic [7:0] x_paddle_top,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] color_out,
    output logic       writeEn,
    output logic       done
);

    localparam int CW     = $clog2(PADDLE_W);
    localparam int CENTER = (XMIN + XMAX + 1 - PADDLE_W) / 2;
    localparam int XLIM   = XMAX - PADDLE_W + 1;

    localparam logic [CW-1:0]     CNT_LAST = CW'(PADDLE_W - 1);
    localparam logic signed [9:0] XMIN_S   = 10'(XMIN);
    localparam logic signed [9:0] XLIM_S   = 10'(XLIM);
    localparam logic signed [9:0] CENTER_S = 10'(CENTER);
    localparam logic signed [9:0] HALF_W_S = 10'(PADDLE_W / 2);

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [7:0]      x_paddle_reg;
    logic [7:0]      x_step;
    logic            skip_reg;
    logic [6:0]      ball_y_reg;
    logic            unused_ball_y;

    logic signed [9:0] offset;
    logic signed [9:0] track;
    logic signed [9:0] target;
    logic signed [9:0] clamped;
    logic signed [9:0] paddle_s;
    logic              step_en;

`ifdef AI_JITTER_EN
    logic [7:0] lfsr_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            lfsr_reg <= 8'hA5;
        else if (state_reg == S_MOVE)
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end

    assign offset = $signed({7'b0, lfsr_reg[2:0]}) - 10'sd4;
`else
    assign offset = '0;
`endif

    // Tracking aims the paddle so the ball lands near its middle; centre target is never jittered.
    always_comb begin
        track    = $signed({2'b00, ball_x}) + 10'sd2 - HALF_W_S + offset;
        target   = ball_y_dir ? CENTER_S : track;
        clamped  = (target < XMIN_S) ? XMIN_S : ((target > XLIM_S) ? XLIM_S : target);
        paddle_s = $signed({2'b00, x_paddle_reg});
        step_en  = difficulty | skip_reg;
        x_step   = x_paddle_reg;
        if (step_en) begin
            if (paddle_s < clamped)
                x_step = x_paddle_reg + 8'd1;
            else if (paddle_s > clamped)
                x_step = x_paddle_reg - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (go) state_next = S_ERASE;
            S_ERASE: if (cnt_reg == CNT_LAST) state_next = S_MOVE;
            S_MOVE:  state_next = S_DRAW;
            S_DRAW:  if (cnt_reg == CNT_LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg      <= '0;
            x_paddle_reg <= 8'(CENTER);
            skip_reg     <= 1'b0;
            ball_y_reg   <= '0;
        end else begin
            if ((state_reg == S_ERASE) || (state_reg == S_DRAW))
                cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
            else
                cnt_reg <= '0;

            if (state_reg == S_MOVE) begin
                x_paddle_reg <= x_step;
                skip_reg     <= ~skip_reg;
                ball_y_reg   <= ball_y;
            end
        end
    end

    // Ball row is kept for debug visibility only; tracking ignores it.
    assign unused_ball_y = ^ball_y_reg;

    always_comb begin
        x_out     = '0;
        y_out     = '0;
        color_out = '0;
        writeEn   = 1'b0;
        done      = 1'b0;
        case (state_reg)
            S_ERASE: begin
                x_out   = x_paddle_reg + 8'(cnt_reg);
                y_out   = 7'(PADDLE_Y);
                writeEn = 1'b1;
            end
            S_DRAW: begin
                x_out     = x_paddle_reg + 8'(cnt_reg);
                y_out     = 7'(PADDLE_Y);
                color_out = PADDLE_COLOR;
                writeEn   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign x_paddle_top = x_paddle_reg;

endmodule
